// File: rtl/core_ras_pkg.sv
// Shared types for the RAS prediction checker: record layout and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_ras_pkg;

  localparam int RAS_AW = 30;

  // One fetch-side prediction record, oldest at the FIFO head
  typedef struct packed {
    logic              pred_pop;
    logic              pred_push;
    logic [RAS_AW-1:0] pop_addr;
  } ras_rec_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REPAIR = 2'd1,
    ST_DRAIN  = 2'd2
  } ras_state_t;

endpackage

// File: rtl/core_ras_check_if.sv
// Fetch/decode/repair signal bundle between the front end and the RAS checker.
// Latency: n/a (wiring only).
// Backpressure: if_stall tells fetch to hold its record.
interface core_ras_check_if #(parameter int AW = 30);

  logic          if_valid;
  logic          if_pred_pop;
  logic          if_pred_push;
  logic [AW-1:0] if_pop_addr;
  logic          if_stall;
  logic          id_valid;
  logic          id_is_ret;
  logic          id_is_call;
  logic          flush_ack;
  logic          recover_push;
  logic [AW-1:0] recover_push_addr;
  logic          recover_pop;
  logic          redirect_req;
  logic          id_ras_miss;

  // Front end side
  modport master (
    output if_valid, if_pred_pop, if_pred_push, if_pop_addr,
    output id_valid, id_is_ret, id_is_call, flush_ack,
    input  if_stall, recover_push, recover_push_addr, recover_pop,
    input  redirect_req, id_ras_miss
  );

  // Checker side
  modport slave (
    input  if_valid, if_pred_pop, if_pred_push, if_pop_addr,
    input  id_valid, id_is_ret, id_is_call, flush_ack,
    output if_stall, recover_push, recover_push_addr, recover_pop,
    output redirect_req, id_ras_miss
  );

endinterface

// File: rtl/core_ras_rec_fifo.sv
// Record FIFO holding in-flight RAS predictions between fetch and decode.
// Latency: write visible at head the cycle after; head is read combinationally.
// Backpressure: writes dropped when full, reads ignored when empty; clr wins.
module core_ras_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic                     clr,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = wr_en && (count != FULL_CNT);
  assign do_rd = rd_en && (count != '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy 0..DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/core_ras_check.sv
// Checks fetch RAS predictions against decode and issues RAS repair + redirect.
// Latency: decode compare at N -> registered repair/miss pulse and redirect at N+1.
// Backpressure: if_stall when record FIFO full; inputs ignored while repairing.
// Optional stats counters enabled by defining RAS_CHECK_STATS_EN.
module core_ras_check
  import core_ras_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic              clk,
  input  logic              rst,
  core_ras_check_if.slave   bus
`ifdef RAS_CHECK_STATS_EN
  ,
  output logic [15:0]       stat_repair,
  output logic [15:0]       stat_miss
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ras_state_t    state;
  ras_state_t    state_nxt;
  ras_rec_t      wr_rec;
  ras_rec_t      head;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          rd_fire;
  logic          fifo_clr;
  logic          mis_pop;
  logic          mis_push;
  logic          unpred_miss;
  logic          repair;

  assign bus.if_stall = (count == FULL_CNT);

  assign wr_rec = '{pred_pop:  bus.if_pred_pop,
                    pred_push: bus.if_pred_push,
                    pop_addr:  RAS_AW'(bus.if_pop_addr)};

  // Decode only consumes records in RUN; an empty FIFO makes id_valid a no-op
  assign rd_fire = (state == ST_RUN) && bus.id_valid && (count != '0);

  // A record with both flags set is judged on its pop alone, so the two
  // repair commands can never fire together
  assign mis_pop     = rd_fire && head.pred_pop && !bus.id_is_ret;
  assign mis_push    = rd_fire && !head.pred_pop && head.pred_push && !bus.id_is_call;
  assign unpred_miss = rd_fire && !head.pred_pop && !head.pred_push &&
                       (bus.id_is_ret || bus.id_is_call);
  assign repair      = mis_pop || mis_push;

  // A front-end flush in RUN wipes the FIFO and beats a same-cycle write
  assign wr_en    = (state == ST_RUN) && bus.if_valid && !bus.if_stall && !bus.flush_ack;
  assign fifo_clr = (state == ST_REPAIR) || ((state == ST_RUN) && bus.flush_ack);

  core_ras_rec_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(ras_rec_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_rec),
    .rd_en   (rd_fire),
    .clr     (fifo_clr),
    .head    (head),
    .count   (count)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // FSM next state: one REPAIR cycle, then DRAIN until the front end acks
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (repair) state_nxt = ST_REPAIR;
      ST_REPAIR: state_nxt = ST_DRAIN;
      ST_DRAIN:  if (bus.flush_ack) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: redirect held for the whole repair/drain window
  always_comb begin
    bus.redirect_req = 1'b0;
    case (state)
      ST_REPAIR, ST_DRAIN: bus.redirect_req = 1'b1;
      default:             bus.redirect_req = 1'b0;
    endcase
  end

  // Registered single-cycle repair and miss pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.recover_push      <= 1'b0;
      bus.recover_push_addr <= '0;
      bus.recover_pop       <= 1'b0;
      bus.id_ras_miss       <= 1'b0;
    end else begin
      bus.recover_push      <= mis_pop;
      bus.recover_push_addr <= mis_pop ? AW'(head.pop_addr) : '0;
      bus.recover_pop       <= mis_push;
      bus.id_ras_miss       <= unpred_miss;
    end
  end

`ifdef RAS_CHECK_STATS_EN
  // Saturating event counters, bumped on each observed output pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_repair <= '0;
      stat_miss   <= '0;
    end else begin
      if ((bus.recover_push || bus.recover_pop) && (stat_repair != 16'hFFFF))
        stat_repair <= stat_repair + 16'd1;
      if (bus.id_ras_miss && (stat_miss != 16'hFFFF))
        stat_miss <= stat_miss + 16'd1;
    end
  end
`endif

endmodule
